obi_mem_arbiter: RTL



---
 rtl/obi_mem_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/obi_mem_arbiter.sv
// Two-manager to one-subordinate OBI arbiter: round-robin address phase with a
// grant lock, and an in-order route FIFO that steers responses back to their manager.
module obi_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [1:0]                m_req_i,
  output logic [1:0]                m_gnt_o,
  input  logic [2*ADDR_WIDTH-1:0]   m_addr_i,
  input  logic [1:0]                m_we_i,
  input  logic [2*DATA_WIDTH/8-1:0] m_be_i,
  input  logic [2*DATA_WIDTH-1:0]   m_wdata_i,
  output logic [1:0]                m_rvalid_o,
  input  logic [1:0]                m_rready_i,
  output logic [DATA_WIDTH-1:0]     m_rdata_o,
  output logic                      s_req_o,
  input  logic                      s_gnt_i,
  output logic [ADDR_WIDTH-1:0]     s_addr_o,
  output logic                      s_we_o,
  output logic [DATA_WIDTH/8-1:0]   s_be_o,
  output logic [DATA_WIDTH-1:0]     s_wdata_o,
  input  logic                      s_rvalid_i,
  output logic                      s_rready_o,
  input  logic [DATA_WIDTH-1:0]     s_rdata_i,
  output logic                      resp_err_o
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);

  logic [MAX_OUTSTANDING-1:0] route_reg;
  logic [PTR_W-1:0]           wr_ptr_reg;
  logic [PTR_W-1:0]           rd_ptr_reg;
  logic [CNT_W-1:0]           count_reg;
  logic                       rr_last_reg;
  logic                       lock_valid_reg;
  logic                       lock_sel_reg;

  logic [ADDR_WIDTH-1:0] m_addr  [2];
  logic [BE_WIDTH-1:0]   m_be    [2];
  logic [DATA_WIDTH-1:0] m_wdata [2];

  logic sel;
  logic not_full;
  logic has_out;
  logic head;
  logic push;
  logic pop;
  logic resp_fwd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    sel = 1'b0;
    if (lock_valid_reg)         sel = lock_sel_reg;
    else if (m_req_i == 2'b10)  sel = 1'b1;
    else if (m_req_i == 2'b11)  sel = ~rr_last_reg;
  end

  assign not_full = (count_reg < CNT_W'(MAX_OUTSTANDING));
  assign has_out  = (count_reg != '0);
  assign head     = route_reg[rd_ptr_reg];

  // Outputs are gated by rst_n_i so they drop in the same instant reset asserts.
  assign s_req_o   = rst_n_i && m_req_i[sel] && not_full;
  assign s_addr_o  = m_addr[sel];
  assign s_we_o    = m_we_i[sel];
  assign s_be_o    = m_be[sel];
  assign s_wdata_o = m_wdata[sel];
  assign push      = s_req_o && s_gnt_i;

  assign s_rready_o = rst_n_i && (has_out ? m_rready_i[head] : 1'b1);
  assign resp_fwd   = rst_n_i && s_rvalid_i && has_out;
  assign pop        = resp_fwd && s_rready_o;
  assign resp_err_o = rst_n_i && s_rvalid_i && !has_out;
  assign m_rdata_o  = s_rdata_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_mgr
      assign m_addr[gi]     = m_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign m_be[gi]       = m_be_i[gi*BE_WIDTH +: BE_WIDTH];
      assign m_wdata[gi]    = m_wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
      assign m_gnt_o[gi]    = push && (sel == 1'(gi));
      assign m_rvalid_o[gi] = resp_fwd && (head == 1'(gi));
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      route_reg      <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      rr_last_reg    <= 1'b1;
      lock_valid_reg <= 1'b0;
      lock_sel_reg   <= 1'b0;
    end else begin
      // Hold the subordinate address phase stable until it is granted.
      if (push) begin
        lock_valid_reg <= 1'b0;
      end else if (s_req_o) begin
        lock_valid_reg <= 1'b1;
        lock_sel_reg   <= sel;
      end

      if (push) begin
        route_reg[wr_ptr_reg] <= sel;
        wr_ptr_reg            <= ptr_inc(wr_ptr_reg);
        rr_last_reg           <= sel;
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end

      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule
